// File: rtl/bit_serial_adder.sv
// +--------------------------------------------------------------------------+
// | bit_serial_adder: LSB-first serial adder, one full-adder slice reused    |
// | WIDTH times with a carry flop; valid/ready on operands and result.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q,  state_d;
    logic [CW-1:0]     cnt_q,    cnt_d;
    logic              carry_q,  carry_d;
    logic [WIDTH-1:0]  a_sr_q,   a_sr_d;
    logic [WIDTH-1:0]  b_sr_q,   b_sr_d;
    logic [WIDTH-1:0]  sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0]  sum_q,    sum_d;
    logic              cout_q,   cout_d;
    logic              ovf_q,    ovf_d;

    logic              w_s;
    logic              w_cn;
    logic [WIDTH-1:0]  w_sum_shifted;

    // Single full-adder slice working on the current LSBs.
    assign w_s  = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign w_cn = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
    assign w_sum_shifted = {w_s, sum_sr_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = carry_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_sr_d = w_sum_shifted;
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                carry_d  = w_cn;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == C_LAST_BIT) begin
                    // carry_q is the carry into the MSB on this last slice.
                    ovf_d   = carry_q ^ w_cn;
                    cout_d  = w_cn;
                    sum_d   = w_sum_shifted;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_bit_serial_adder.sv
// +--------------------------------------------------------------------------+
// | tb_bit_serial_adder: directed vectors against an arithmetic model of the |
// | serial adder, plus literal expectations. Revision: 1.0                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_bit_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             busy;

    int n_vec  = 0;
    int n_miss = 0;

    bit_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a timeline of the operation (idle / counting bit cycles / result
    // waiting) with the result taken from plain integer addition.
    int               m_phase = 0;     // 0 idle, 1 running, 2 result pending
    int               m_cyc   = 0;
    logic [WIDTH-1:0] m_sum   = '0;
    logic             m_cout  = 1'b0;
    logic             m_ovf   = 1'b0;
    logic [WIDTH-1:0] p_sum;
    logic             p_cout;
    logic             p_ovf;
    bit               cmp_en  = 1'b0;

    always @(posedge clk) begin
        logic [WIDTH:0] r;
        if (rst) begin
            m_phase = 0;
            m_sum   = '0;
            m_cout  = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    r      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
                    p_sum  = r[WIDTH-1:0];
                    p_cout = r[WIDTH];
                    p_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
                    m_cyc  = 0;
                    m_phase = 1;
                end
                1: begin
                    m_cyc++;
                    if (m_cyc == WIDTH) begin
                        m_sum   = p_sum;
                        m_cout  = p_cout;
                        m_ovf   = p_ovf;
                        m_phase = 2;
                    end
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready",  {31'd0, in_ready},  {31'd0, m_phase == 0});
            chk("busy",      {31'd0, busy},      {31'd0, m_phase == 1});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_phase == 2});
            chk("sum",       32'(sum),           32'(m_sum));
            chk("carry_out", {31'd0, carry_out}, {31'd0, m_cout});
            chk("overflow",  {31'd0, overflow},  {31'd0, m_ovf});
        end
    end

    // Called #1 after an edge with the DUT in IDLE; issues one op and
    // checks latency, literal result and backpressure hold.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic cin,
                         input logic [7:0] es, input logic ec, input logic eo,
                         input int hold);
        int lat;
        chk("pre_in_ready", {31'd0, in_ready}, 32'd1);
        a = av; b = bv; carry_in = cin; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = '0; b = '0; carry_in = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency",  32'(lat), 32'd8);
        chk("lit_sum",  32'(sum), 32'(es));
        chk("lit_cout", {31'd0, carry_out}, {31'd0, ec});
        chk("lit_ovf",  {31'd0, overflow},  {31'd0, eo});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_sum",   32'(sum), 32'(es));
            chk("hold_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; carry_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum",       32'(sum),           32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 0);
        do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0);
        do_op(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 0);
        do_op(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 0);
        do_op(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 0);
        do_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 5);
        do_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 0);

        // Abort an operation after four bit cycles.
        a = 8'hAA; b = 8'h55; carry_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready",  {31'd0, in_ready},  32'd1);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_sum",       32'(sum),           32'd0);
        do_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 0);

        // in_valid held through DONE must not start a new op early.
        a = 8'h05; b = 8'h06; carry_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1;
        chk("done_ignores_valid", {31'd0, in_ready}, 32'd0);
        chk("done_sum",           32'(sum),          32'h0B);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("final_idle", {31'd0, in_ready}, 32'd1);

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
- Sequential LSB-first adder. It is the addition counterpart of the team's full subtractor cell.
- One full-adder bit slice plus a carry flop are reused for WIDTH cycles to produce A+B+carry_in.
- Sits beside the GCD subtract datapath. It serves the reconstruction/accumulate path, e.g. LCM = a*b/gcd via repeated add.
- Valid/ready handshake on both input and output. One operation in flight at a time.

Parameters:
- WIDTH, 8, operand and sum width in bits. Legal range is WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand handshake valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A, two's-complement or unsigned.
- b  input  WIDTH  operand B.
- carry_in  input  1  carry into bit 0.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  result consumer ready.
- sum  output  WIDTH  registered result (A+B+carry_in) mod 2^WIDTH.
- carry_out  output  1  carry out of bit WIDTH-1 (unsigned overflow).
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- busy  output  1  high in RUN.

Behaviour:
- Reset: rst is sampled on the rising clk edge.
  - On reset: state = IDLE, bit counter = 0, internal carry = 0, operand shift registers = 0.
  - On reset: sum = 0, carry_out = 0, overflow = 0, out_valid = 0, busy = 0, in_ready = 1 (IDLE).
  - Reset during RUN or DONE aborts the operation. No result is produced and the operand is discarded.
- FSM states are IDLE, RUN and DONE. All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1: capture a, b into shift regs, carry <= carry_in, counter <= 0, then go to RUN.
  - in_valid = 0 keeps the block in IDLE.
- RUN (one bit per cycle):
  - s = a_sr[0] ^ b_sr[0] ^ carry.
  - Next carry = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry).
  - s is shifted into sum_sr from the MSB side. a_sr and b_sr shift right by 1. Counter increments.
  - On the edge processing bit WIDTH-1:
    - overflow <= carry (carry into MSB) XOR next carry.
    - carry_out <= next carry.
    - sum <= completed sum_sr.
    - Go to DONE.
  - in_valid is ignored during RUN (in_ready = 0).
- DONE:
  - out_valid = 1. sum, carry_out and overflow are held stable until accepted.
  - On an edge with out_ready = 1: go to IDLE. in_ready rises the following cycle.
  - out_ready = 0 holds DONE indefinitely (backpressure); the result does not change.
- Latency:
  - Acceptance at edge E0. out_valid is first high in the cycle after edge E_WIDTH, i.e. WIDTH cycles after acceptance.
  - Minimum issue interval is WIDTH + 2 cycles (accept, WIDTH bit cycles, one DONE cycle).
- Output hold after handshake: sum, carry_out and overflow keep their last values after the handshake until the next op completes. They are only meaningful while out_valid = 1.
- Unsigned interpretation: {carry_out, sum} is the exact WIDTH+1-bit result.
- Signed interpretation: sum is correct iff overflow = 0.
- Simultaneous events:
  - rst has priority over every handshake.
  - in_valid asserted during DONE is not accepted until back in IDLE.

Test Plan:
- WIDTH=8, a=0x35, b=0x4A, cin=0, out_ready=1 -> out_valid exactly 8 cycles after accept; sum=0x7F, carry_out=0, overflow=0.
- a=0x7F, b=0x01, cin=0 -> sum=0x80, carry_out=0, overflow=1.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, carry_out=1, overflow=0. Also a=0x80, b=0x80 -> sum=0x00, carry_out=1, overflow=1.
- a=0xFF, b=0x00, cin=1 -> sum=0x00, carry_out=1, overflow=0.
- Backpressure on a=0x12, b=0x34:
  - Hold out_ready=0 for 5 cycles -> out_valid stays 1, sum=0x46 stable, in_ready=0 throughout.
  - Assert out_ready -> IDLE next cycle.
  - A second op (a=0x01, b=0x02) issued back-to-back -> sum=0x03.
- Reset mid-operation:
  - Accept a=0xAA, b=0x55, assert rst at bit cycle 4 -> next cycle in IDLE, in_ready=1, out_valid=0, sum=0.
  - A new op a=0x10, b=0x20 -> sum=0x30; no residue of the aborted op.
